// File: rtl/rob_commit.sv
// rob_commit: in-order retirement buffer (reorder buffer) for the I2OI core.
// Write side: in-order allocation from Issue, out-of-order completion from
// Execute/Writeback. Read side: one in-order retirement per cycle toward the
// ARF write port and the finished-store buffer.
//
// Optional build macro: ROB_BYPASS_EN
//   defined   - a completion aimed at the valid head entry retires it on the
//               same edge, using the completing data.
//   undefined - retirement waits for the stored done bit (one extra cycle).
module rob_commit #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  // allocation from Issue
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  input  logic             alloc_regwrite,
  input  logic             alloc_store,
  output logic             alloc_ready,
  output logic [PTR_W-1:0] alloc_tag,
  // completion from Execute/Writeback
  input  logic             done_valid,
  input  logic [PTR_W-1:0] done_tag,
  input  logic [31:0]      done_data,
  // squash
  input  logic             flush,
  // retirement
  output logic             commit_valid,
  output logic             commit_regwrite,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_data,
  output logic             commit_store,
  output logic [PTR_W-1:0] commit_tag,
  // occupancy
  output logic [PTR_W:0]   count,
  output logic             empty
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  // entry storage, one bit/field per slot
  logic [DEPTH-1:0]       r_valid;
  logic [DEPTH-1:0]       r_done;
  logic [DEPTH-1:0]       r_rw;
  logic [DEPTH-1:0]       r_st;
  logic [DEPTH-1:0][4:0]  r_rd;
  logic [DEPTH-1:0][31:0] r_data;

  // pointers and occupancy
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  // registered commit port
  logic             r_cv;
  logic             r_crw;
  logic [4:0]       r_crd;
  logic [31:0]      r_cdata;
  logic             r_cst;
  logic [PTR_W-1:0] r_ctag;

  logic        w_alloc;
  logic        w_hit;
  logic        w_byp;
  logic        w_retire;
  logic [31:0] w_ret_data;

  // Full blocks allocation even if the head retires this cycle; the freed
  // slot only becomes available on the following cycle.
  assign alloc_ready = (r_count < DEPTH_C) && !flush;
  assign alloc_tag   = r_tail;
  assign w_alloc     = alloc_valid && alloc_ready;

  // Completions to slots that are not live (stale or post-flush tags) drop.
  assign w_hit = done_valid && r_valid[done_tag];

`ifdef ROB_BYPASS_EN
  // A completion hitting the live head retires it on the same edge.
  assign w_byp = done_valid && (done_tag == r_head) && r_valid[r_head];
`else
  assign w_byp = 1'b0;
`endif

  assign w_retire   = r_valid[r_head] && (r_done[r_head] || w_byp);
  assign w_ret_data = w_byp ? done_data : r_data[r_head];

  // Entry updates: completion, then retire clear, then allocation; later
  // assignments win. Alloc and retire never target the same slot because
  // allocation is blocked when full and retire needs a live head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_done  <= '0;
      r_rw    <= '0;
      r_st    <= '0;
      r_rd    <= '0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      if (w_hit) begin
        r_done[done_tag] <= 1'b1;
        r_data[done_tag] <= done_data;
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_rd[r_tail]    <= alloc_rd;
        r_rw[r_tail]    <= alloc_regwrite;
        r_st[r_tail]    <= alloc_store;
      end
    end
  end

  // Head/tail pointers wrap naturally at DEPTH (power of two); count is
  // kept separately so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc)  r_tail <= r_tail + 1'b1;
      if (w_retire) r_head <= r_head + 1'b1;
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Commit port: pulse valid per retirement, other fields hold between.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cv    <= 1'b0;
      r_crw   <= 1'b0;
      r_crd   <= '0;
      r_cdata <= '0;
      r_cst   <= 1'b0;
      r_ctag  <= '0;
    end else if (flush) begin
      r_cv <= 1'b0;
    end else if (w_retire) begin
      r_cv    <= 1'b1;
      r_crw   <= r_rw[r_head] && (r_rd[r_head] != 5'd0);
      r_crd   <= r_rd[r_head];
      r_cdata <= w_ret_data;
      r_cst   <= r_st[r_head];
      r_ctag  <= r_head;
    end else begin
      r_cv <= 1'b0;
    end
  end

  assign commit_valid    = r_cv;
  assign commit_regwrite = r_crw;
  assign commit_rd       = r_crd;
  assign commit_data     = r_cdata;
  assign commit_store    = r_cst;
  assign commit_tag      = r_ctag;
  assign count           = r_count;
  assign empty           = (r_count == '0);

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed scenarios followed by random
// traffic, all compared against a program-order queue model.
module tb_rob_commit;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             alloc_valid = 1'b0;
  logic [4:0]       alloc_rd = '0;
  logic             alloc_regwrite = 1'b0;
  logic             alloc_store = 1'b0;
  logic             alloc_ready;
  logic [PTR_W-1:0] alloc_tag;
  logic             done_valid = 1'b0;
  logic [PTR_W-1:0] done_tag = '0;
  logic [31:0]      done_data = '0;
  logic             flush = 1'b0;
  logic             commit_valid;
  logic             commit_regwrite;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_data;
  logic             commit_store;
  logic [PTR_W-1:0] commit_tag;
  logic [PTR_W:0]   count;
  logic             empty;

  rob_commit #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_regwrite(alloc_regwrite), .alloc_store(alloc_store),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .done_valid(done_valid), .done_tag(done_tag), .done_data(done_data),
    .flush(flush),
    .commit_valid(commit_valid), .commit_regwrite(commit_regwrite),
    .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_store(commit_store), .commit_tag(commit_tag),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

`ifdef ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // model: live instructions in program order
  typedef struct {
    int          tag;
    logic [4:0]  rd;
    logic        rw;
    logic        st;
    logic        dn;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rw;
    logic        st;
  } cmt_t;

  ent_t q[$];
  cmt_t log_q[$];
  int   ntag;
  logic        e_cv, e_rw, e_st;
  logic [4:0]  e_rd;
  logic [31:0] e_data;
  int          e_tag;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    ntag = 0;
    e_cv = 0; e_rw = 0; e_st = 0; e_rd = 0; e_data = 0; e_tag = 0;
  endfunction

  // One clock edge of the model, given the inputs present before the edge.
  function automatic void model_edge(input logic av, input logic [4:0] ard,
                                     input logic arw, input logic ast,
                                     input logic dv, input int dtag,
                                     input logic [31:0] dd, input logic fl);
    bit   ret, byp, can_alloc;
    ent_t n;
    if (fl) begin
      q.delete();
      ntag = 0;
      e_cv = 0;
      return;
    end
    can_alloc = av && (q.size() < DEPTH);
    ret = 0; byp = 0;
    if (q.size() > 0) begin
      if (BYP && dv && dtag == q[0].tag) begin ret = 1; byp = 1; end
      else if (q[0].dn) ret = 1;
    end
    if (ret) begin
      e_cv   = 1;
      e_rd   = q[0].rd;
      e_rw   = q[0].rw && (q[0].rd != 0);
      e_st   = q[0].st;
      e_tag  = q[0].tag;
      e_data = byp ? dd : q[0].data;
    end else e_cv = 0;
    if (dv)
      foreach (q[k]) if (q[k].tag == dtag) begin q[k].dn = 1; q[k].data = dd; end
    if (ret) void'(q.pop_front());
    if (can_alloc) begin
      n.tag = ntag; n.rd = ard; n.rw = arw; n.st = ast; n.dn = 0; n.data = 0;
      q.push_back(n);
      ntag = (ntag + 1) % DEPTH;
    end
  endfunction

  // Called at a negedge: drive inputs, check combinational outputs, take one
  // edge, then check registered outputs at the following negedge.
  task automatic step(input logic av, input logic [4:0] ard, input logic arw,
                      input logic ast, input logic dv, input logic [2:0] dtag,
                      input logic [31:0] dd, input logic fl);
    cmt_t c;
    alloc_valid = av; alloc_rd = ard; alloc_regwrite = arw; alloc_store = ast;
    done_valid = dv; done_tag = dtag; done_data = dd; flush = fl;
    #1;
    chk("alloc_ready", alloc_ready, (q.size() < DEPTH) && !fl);
    chk("alloc_tag", alloc_tag, ntag);
    @(posedge clk);
    model_edge(av, ard, arw, ast, dv, int'(dtag), dd, fl);
    @(negedge clk);
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("commit_valid", commit_valid, e_cv);
    chk("commit_regwrite", commit_regwrite, e_rw);
    chk("commit_rd", commit_rd, e_rd);
    chk("commit_data", commit_data, e_data);
    chk("commit_store", commit_store, e_st);
    chk("commit_tag", commit_tag, e_tag);
    if (commit_valid) begin
      c.rd = commit_rd; c.data = commit_data; c.rw = commit_regwrite; c.st = commit_store;
      log_q.push_back(c);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input logic [4:0] rd, input logic rw, input logic st);
    step(1, rd, rw, st, 0, 0, 0, 0);
  endtask

  task automatic done(input logic [2:0] t, input logic [31:0] d);
    step(0, 0, 0, 0, 1, t, d, 0);
  endtask

  // Reset asserted in the middle of the low phase; checks the async effect.
  task automatic do_reset();
    alloc_valid = 0; done_valid = 0; flush = 0;
    #2 rst = 1;
    #1;
    model_reset();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_cv", commit_valid, 0);
    chk("rst_crw", commit_regwrite, 0);
    chk("rst_crd", commit_rd, 0);
    chk("rst_cdata", commit_data, 0);
    chk("rst_cst", commit_store, 0);
    chk("rst_ctag", commit_tag, 0);
    @(negedge clk);
    rst = 0;
    log_q.delete();
  endtask

  initial begin
    logic [2:0] dt;
    model_reset();
    @(negedge clk);
    do_reset();

    // out-of-order completion, in-order retirement
    alloc(4, 1, 0); alloc(5, 1, 0); alloc(6, 1, 0);
    done(2, 32'h30); done(0, 32'h10); done(1, 32'h20);
    idle(3);
    chk("ooo_n", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("ooo0_rd", log_q[0].rd, 4); chk("ooo0_d", log_q[0].data, 32'h10);
      chk("ooo1_rd", log_q[1].rd, 5); chk("ooo1_d", log_q[1].data, 32'h20);
      chk("ooo2_rd", log_q[2].rd, 6); chk("ooo2_d", log_q[2].data, 32'h30);
    end

    // full and wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(5'(i + 1), 1, 0);
    chk("full_cnt", count, DEPTH);
    #1 chk("full_ready", alloc_ready, 0);
    done(0, 32'hA0);
    idle(1);
    chk("after_ret_cnt", count, DEPTH - 1);
    #1 chk("after_ret_ready", alloc_ready, 1);
    chk("wrap_tag", alloc_tag, 0);
    alloc(20, 1, 0);
    for (int i = 1; i < DEPTH; i++) done(3'(i), 32'hB0 + 32'(i));
    done(0, 32'hC0);
    idle(3);
    chk("wrap_n", log_q.size(), DEPTH + 1);
    if (log_q.size() == DEPTH + 1) begin
      chk("wrap_last_rd", log_q[DEPTH].rd, 20);
      chk("wrap_last_d", log_q[DEPTH].data, 32'hC0);
    end
    chk("wrap_empty", empty, 1);

    // x0 destination and store
    do_reset();
    alloc(0, 1, 0); alloc(9, 0, 1);
    done(0, 32'h1); done(1, 32'h2);
    idle(2);
    chk("x0_n", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("x0_rw", log_q[0].rw, 0); chk("x0_st", log_q[0].st, 0);
      chk("st_rw", log_q[1].rw, 0); chk("st_st", log_q[1].st, 1);
    end

    // flush with pending work, then a late completion to an old tag
    do_reset();
    alloc(1, 1, 0); alloc(2, 1, 0); alloc(3, 1, 0);
    done(1, 32'h77);
    step(0, 0, 0, 0, 1, 0, 32'h99, 1);
    chk("fl_cnt", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_cv", commit_valid, 0);
    done(1, 32'h88);
    idle(2);
    chk("fl_late_cnt", count, 0);
    chk("fl_no_commit", log_q.size(), 0);

    // head bypass timing
    do_reset();
    alloc(7, 1, 0);
    done(0, 32'h55);
`ifdef ROB_BYPASS_EN
    chk("byp_cv_n", commit_valid, 1);
    chk("byp_d_n", commit_data, 32'h55);
    idle(1);
    chk("byp_cv_n1", commit_valid, 0);
`else
    chk("byp_cv_n", commit_valid, 0);
    idle(1);
    chk("byp_cv_n1", commit_valid, 1);
    chk("byp_d_n1", commit_data, 32'h55);
`endif

    // random traffic against the model, with a reset in the middle
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      if (q.size() > 0 && $urandom_range(0, 4) != 0)
        dt = 3'(q[$urandom_range(0, q.size() - 1)].tag);
      else
        dt = 3'($urandom_range(0, DEPTH - 1));
      step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 6, dt, $urandom(),
           $urandom_range(0, 39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rob_commit.md
# rob_commit

In-order retirement buffer for the I2OI core: a circular reorder buffer whose write side takes in-order allocations from Issue and out-of-order completions from Execute/Writeback. Its read side retires one entry per cycle in program order toward the ARF write port and the finished-store buffer. It sits between the Writeback stage and the architectural state.

## Interface
- DEPTH, 8, number of entries; power of two, 2..32
- PTR_W, 3, log2(DEPTH); tag and pointer width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- alloc_valid  in  1  Issue requests an entry this cycle
- alloc_rd  in  5  destination register of the allocated instruction
- alloc_regwrite  in  1  instruction writes a register
- alloc_store  in  1  instruction is a store
- alloc_ready  out  1  entry available, combinational: count < DEPTH and !flush
- alloc_tag  out  PTR_W  tag given to the allocation (current tail pointer)
- done_valid  in  1  a result is completing this cycle
- done_tag  in  PTR_W  tag of the completing entry
- done_data  in  32  result value (aluout or readdata)
- flush  in  1  discard all entries (branch taken / squash)
- commit_valid  out  1  registered; one entry retired on the previous edge
- commit_regwrite  out  1  registered; ARF write enable, forced 0 when rd == 0
- commit_rd  out  5  registered; ARF write address
- commit_data  out  32  registered; ARF write data
- commit_store  out  1  registered; release pulse to the finished-store buffer
- commit_tag  out  PTR_W  registered; tag of the retired entry
- count  out  PTR_W+1  occupied entries
- empty  out  1  count == 0

## Operation
- Each entry holds valid, done, rd, regwrite, store and data[31:0]. head and tail are PTR_W-bit pointers that wrap modulo DEPTH. count is a separate counter.
- **Allocate** (alloc_valid & alloc_ready): write rd/regwrite/store into entry[tail]; set valid=1 and done=0; tail += 1.
- **Complete** (done_valid): if entry[done_tag].valid, set done=1 and data=done_data. Otherwise the completion is ignored.
- **Retire:** when entry[head].valid & entry[head].done, register the entry fields onto the commit_* outputs with commit_valid=1, clear valid, and advance head += 1. Otherwise commit_valid=0 and the other commit_* outputs hold their values.
- **Count:** count += alloc − retire. Simultaneous alloc and retire leaves count unchanged.
- **Full:** alloc_ready=0 while count == DEPTH, even if a retire happens in the same cycle. No same-cycle reuse of the freed slot.
- **Repeated done:** a second done to an already-done entry overwrites data.
- **Flush** (synchronous, highest priority): clears every valid and done bit; head=tail=count=0; commit_valid=0 on the next edge. Alloc, done and retire in the flush cycle are discarded.
- **Reset** (asynchronous): head=tail=count=0; all valid/done=0; commit_valid=0, commit_regwrite=0, commit_rd=0, commit_data=0, commit_store=0, commit_tag=0. A reset asserted mid-operation drops all entries immediately.
- Stores retire with commit_store=1. commit_regwrite is taken from the entry, ANDed with (rd != 0).

## Timing
- alloc_tag and alloc_ready are combinational from the current state.
- Without bypass, done at edge N sets the done bit. If that entry is at head, it retires at edge N+1, and commit_* is visible after N+1.
- Maximum throughput is one allocation and one retirement per cycle.
- An entry allocated at edge N can complete in the cycle after edge N.
- commit_valid is a single-cycle pulse per retired entry.
- Back-to-back retirements produce consecutive commit_valid cycles.

## Configuration
- ROB_BYPASS_EN
  - Defined: when done_valid & done_tag == head & entry[head].valid, the head entry retires at the same edge, using done_data. Retirement latency is edge N, one cycle earlier than without the macro.
  - Undefined: retirement requires the stored done bit, as described under Timing.
  - Flush priority and all other behaviour are identical in both builds.

## Test plan
- **Reset and empty:** assert rst mid-cycle, then release, with DEPTH=8 -> empty=1, count=0, alloc_tag=0, all commit_* = 0.
- **In-order retire from out-of-order completion:** allocate tags 0,1,2 (rd=4,5,6); complete tag 2 (data 0x30), then tag 0 (0x10), then tag 1 (0x20) -> commit sequence is rd4/0x10, rd5/0x20, rd6/0x30 on consecutive commit_valid pulses. Tag 2 must not commit first.
- **Full and wrap:** allocate 8 entries -> alloc_ready=0 and count=8. Retire one -> alloc_ready=1. The next allocation gets alloc_tag=0 (wrap), and commits continue correctly past index 7.
- **x0 and store:** allocate rd=0 with regwrite=1, then a store; complete both -> commit_regwrite=0 on both retirements; commit_store=1 only on the second.
- **Flush with pending work:** three allocated entries, one done, assert flush -> next cycle count=0, empty=1, no commit_valid pulse. A late done to an old tag is ignored.
- **Bypass:** done to the head tag with data 0x55 at edge N -> with ROB_BYPASS_EN, commit_data=0x55 after edge N; without it, after edge N+1.
